// File: rtl/pb_bus_initiator.sv
// pb_bus_initiator: command-driven initiator for the 8-bit port bus.
// Accepts one register read or write command on a valid/ready channel and
// replays it on port_id/out_port/in_port with single-cycle strobes.
// Read data comes back on a valid/ready response channel.
// Optional feature: define PB_INIT_WRITE_RSP_EN to make writes return an
// acknowledge response carrying the written data.
// By default, writes are posted and produce no response.
module pb_bus_initiator #(
    parameter int READ_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_write,
    output logic [7:0] rsp_data,
    output logic [7:0] port_id,
    output logic [7:0] out_port,
    input  logic [7:0] in_port,
    output logic       write_strobe,
    output logic       read_strobe,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        WR_STB  = 3'd2,
        RD_WAIT = 3'd3,
        RESP    = 3'd4
    } state_t;

    // The read phase lasts READ_LAT cycles; the strobe fires when the counter hits 0.
    localparam logic [2:0] CNT_LOAD = 3'(READ_LAT - 1);

    state_t     state_q, state_d;
    logic [7:0] port_id_q, port_id_d;
    logic [7:0] out_port_q, out_port_d;
    logic       write_q, write_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] rsp_data_q, rsp_data_d;
`ifdef PB_INIT_WRITE_RSP_EN
    logic       rsp_write_q, rsp_write_d;
`endif

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            port_id_q   <= 8'h00;
            out_port_q  <= 8'h00;
            write_q     <= 1'b0;
            cnt_q       <= 3'd0;
            rsp_data_q  <= 8'h00;
`ifdef PB_INIT_WRITE_RSP_EN
            rsp_write_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            port_id_q   <= port_id_d;
            out_port_q  <= out_port_d;
            write_q     <= write_d;
            cnt_q       <= cnt_d;
            rsp_data_q  <= rsp_data_d;
`ifdef PB_INIT_WRITE_RSP_EN
            rsp_write_q <= rsp_write_d;
`endif
        end
    end

    // Next-state logic: command capture, bus sequencing and response hold.
    always_comb begin
        state_d     = state_q;
        port_id_d   = port_id_q;
        out_port_d  = out_port_q;
        write_d     = write_q;
        cnt_d       = cnt_q;
        rsp_data_d  = rsp_data_q;
`ifdef PB_INIT_WRITE_RSP_EN
        rsp_write_d = rsp_write_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    // Address and data stay put after the transfer; only strobes qualify it.
                    port_id_d = cmd_addr;
                    if (cmd_write) begin
                        out_port_d = cmd_wdata;
                    end
                    write_d = cmd_write;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (write_q) begin
                    state_d = WR_STB;
                end else begin
                    cnt_d   = CNT_LOAD;
                    state_d = RD_WAIT;
                end
            end
            WR_STB: begin
`ifdef PB_INIT_WRITE_RSP_EN
                rsp_data_d  = out_port_q;
                rsp_write_d = 1'b1;
                state_d     = RESP;
`else
                state_d     = IDLE;
`endif
            end
            RD_WAIT: begin
                if (cnt_q == 3'd0) begin
                    rsp_data_d  = in_port;
`ifdef PB_INIT_WRITE_RSP_EN
                    rsp_write_d = 1'b0;
`endif
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registers or pure state decodes, so strobes drop with reset.
    assign cmd_ready    = (state_q == IDLE) && !reset;
    assign busy         = (state_q != IDLE);
    assign write_strobe = (state_q == WR_STB);
    assign read_strobe  = (state_q == RD_WAIT) && (cnt_q == 3'd0);
    assign rsp_valid    = (state_q == RESP);
    assign rsp_data     = rsp_data_q;
    assign port_id      = port_id_q;
    assign out_port     = out_port_q;
`ifdef PB_INIT_WRITE_RSP_EN
    assign rsp_write    = rsp_write_q;
`else
    assign rsp_write    = 1'b0;
`endif

endmodule

// File: tb/tb_pb_bus_initiator.sv
// tb_pb_bus_initiator: directed bench for pb_bus_initiator.
// Instance dut uses READ_LAT=1 against a small register-file slave model.
// Instance dut3 uses READ_LAT=3 with in_port driven directly.
// Build with or without PB_INIT_WRITE_RSP_EN.
module tb_pb_bus_initiator;

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    // READ_LAT = 1 instance
    logic       cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b1;
    logic [7:0] cmd_addr = 8'h00, cmd_wdata = 8'h00;
    logic       cmd_ready, rsp_valid, rsp_write, write_strobe, read_strobe, busy;
    logic [7:0] rsp_data, port_id, out_port;
    logic [7:0] in_port = 8'h00;

    // READ_LAT = 3 instance
    logic       cmd_valid3 = 1'b0, cmd_write3 = 1'b0, rsp_ready3 = 1'b0;
    logic [7:0] cmd_addr3 = 8'h00, cmd_wdata3 = 8'h00;
    logic       cmd_ready3, rsp_valid3, rsp_write3, write_strobe3, read_strobe3, busy3;
    logic [7:0] rsp_data3, port_id3, out_port3;
    logic [7:0] in_port3 = 8'h00;

    logic [7:0] regs [0:255];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pb_bus_initiator #(.READ_LAT(1)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_data(rsp_data), .port_id(port_id), .out_port(out_port),
        .in_port(in_port), .write_strobe(write_strobe), .read_strobe(read_strobe),
        .busy(busy)
    );

    pb_bus_initiator #(.READ_LAT(3)) dut3 (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_write(cmd_write3),
        .cmd_addr(cmd_addr3), .cmd_wdata(cmd_wdata3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_write(rsp_write3),
        .rsp_data(rsp_data3), .port_id(port_id3), .out_port(out_port3),
        .in_port(in_port3), .write_strobe(write_strobe3), .read_strobe(read_strobe3),
        .busy(busy3)
    );

    // Register-file slave: writes on write_strobe, in_port registered one cycle after port_id.
    always @(posedge clk) begin
        if (write_strobe) regs[port_id] <= out_port;
        in_port <= regs[port_id];
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_wdata = d;
        tick;                                   // accept edge -> SETUP
        cmd_valid = 1'b0; cmd_addr = ~a; cmd_wdata = ~d;
        check("wr_setup_pid", port_id, a);
        check("wr_setup_dout", out_port, d);
        check("wr_setup_wstb", {7'b0, write_strobe}, 8'h00);
        check("wr_setup_rdy", {7'b0, cmd_ready}, 8'h00);
        tick;                                   // WR_STB
        check("wr_stb_wstb", {7'b0, write_strobe}, 8'h01);
        check("wr_stb_pid", port_id, a);
        check("wr_stb_dout", out_port, d);
        check("wr_stb_rvld", {7'b0, rsp_valid}, 8'h00);
        tick;
        check("wr_after_wstb", {7'b0, write_strobe}, 8'h00);
`ifdef PB_INIT_WRITE_RSP_EN
        check("wr_rsp_vld", {7'b0, rsp_valid}, 8'h01);
        check("wr_rsp_write", {7'b0, rsp_write}, 8'h01);
        check("wr_rsp_data", rsp_data, d);
        tick;
`endif
        check("wr_idle_rvld", {7'b0, rsp_valid}, 8'h00);
        check("wr_idle_rdy", {7'b0, cmd_ready}, 8'h01);
        check("wr_idle_busy", {7'b0, busy}, 8'h00);
        $display("[TB] write addr=%h data=%h done", a, d);
    endtask

    task automatic do_read(input logic [7:0] a, input logic [7:0] exp);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a;
        tick;                                   // accept edge -> SETUP
        cmd_valid = 1'b0; cmd_addr = ~a;
        check("rd_setup_rstb", {7'b0, read_strobe}, 8'h00);
        check("rd_setup_pid", port_id, a);
        check("rd_setup_rvld", {7'b0, rsp_valid}, 8'h00);
        tick;                                   // RD_WAIT
        check("rd_wait_rstb", {7'b0, read_strobe}, 8'h01);
        check("rd_wait_rvld", {7'b0, rsp_valid}, 8'h00);
        tick;                                   // RESP, 3rd cycle counting the accept cycle
        check("rd_resp_rstb", {7'b0, read_strobe}, 8'h00);
        check("rd_resp_vld", {7'b0, rsp_valid}, 8'h01);
        check("rd_resp_data", rsp_data, exp);
        check("rd_resp_write", {7'b0, rsp_write}, 8'h00);
        check("rd_resp_rdy", {7'b0, cmd_ready}, 8'h00);
        tick;                                   // rsp_ready high: back to IDLE
        check("rd_idle_rvld", {7'b0, rsp_valid}, 8'h00);
        check("rd_idle_rdy", {7'b0, cmd_ready}, 8'h01);
        $display("[TB] read addr=%h data=%h done", a, rsp_data);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) regs[i] = 8'h00;

        // Reset values
        tick; tick;
        check("rst_rdy", {7'b0, cmd_ready}, 8'h00);
        check("rst_busy", {7'b0, busy}, 8'h00);
        check("rst_pid", port_id, 8'h00);
        check("rst_dout", out_port, 8'h00);
        check("rst_wstb", {7'b0, write_strobe}, 8'h00);
        check("rst_rstb", {7'b0, read_strobe}, 8'h00);
        check("rst_rvld", {7'b0, rsp_valid}, 8'h00);
        check("rst_rwrite", {7'b0, rsp_write}, 8'h00);
        check("rst_rdata", rsp_data, 8'h00);
        reset = 1'b0;
        #1;
        check("rel_rdy", {7'b0, cmd_ready}, 8'h01);
        $display("[TB] reset released");
        tick;

        // Write 0xA5 to addr 0x00
        do_write(8'h00, 8'hA5);
        check("slave_spcr", regs[0], 8'hA5);

        // Write then read back addr 0x01
        do_write(8'h01, 8'h3C);
        do_read(8'h01, 8'h3C);

        // Response back-pressure
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h01;
        tick;                                   // SETUP
        cmd_valid = 1'b0;
        tick;                                   // RD_WAIT
        tick;                                   // RESP
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h00;
        for (int i = 0; i < 5; i++) begin
            check("bp_vld", {7'b0, rsp_valid}, 8'h01);
            check("bp_data", rsp_data, 8'h3C);
            check("bp_rdy", {7'b0, cmd_ready}, 8'h00);
            tick;
        end
        rsp_ready = 1'b1;
        tick;                                   // response consumed -> IDLE
        check("bp_idle_rdy", {7'b0, cmd_ready}, 8'h01);
        check("bp_idle_busy", {7'b0, busy}, 8'h00);
        check("bp_idle_pid", port_id, 8'h01);
        tick;                                   // pending command accepted
        cmd_valid = 1'b0;
        check("bp_acc_busy", {7'b0, busy}, 8'h01);
        check("bp_acc_pid", port_id, 8'h00);
        tick; tick;
        check("bp_rd2_vld", {7'b0, rsp_valid}, 8'h01);
        check("bp_rd2_data", rsp_data, 8'hA5);
        tick;
        $display("[TB] back-pressure read done");

        // Reset during RD_WAIT
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h01;
        tick;
        cmd_valid = 1'b0;
        tick;                                   // RD_WAIT, strobe high
        check("mid_rstb_pre", {7'b0, read_strobe}, 8'h01);
        #2 reset = 1'b1;
        #1;
        check("mid_rstb", {7'b0, read_strobe}, 8'h00);
        check("mid_wstb", {7'b0, write_strobe}, 8'h00);
        check("mid_rvld", {7'b0, rsp_valid}, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            check("post_rst_rvld", {7'b0, rsp_valid}, 8'h00);
            check("post_rst_rdy", {7'b0, cmd_ready}, 8'h01);
        end
        $display("[TB] reset mid-read done");

        // Posted (or acknowledged) write of 0x77
        do_write(8'h02, 8'h77);

        // READ_LAT = 3 instance
        in_port3 = 8'h5A;
        cmd_valid3 = 1'b1; cmd_write3 = 1'b0; cmd_addr3 = 8'h10;
        tick;                                   // SETUP
        cmd_valid3 = 1'b0;
        check("l3_setup_rstb", {7'b0, read_strobe3}, 8'h00);
        tick;
        check("l3_wait1_rstb", {7'b0, read_strobe3}, 8'h00);
        tick;
        check("l3_wait2_rstb", {7'b0, read_strobe3}, 8'h00);
        tick;
        check("l3_wait3_rstb", {7'b0, read_strobe3}, 8'h01);
        check("l3_wait3_rvld", {7'b0, rsp_valid3}, 8'h00);
        tick;                                   // RESP
        check("l3_resp_vld", {7'b0, rsp_valid3}, 8'h01);
        check("l3_resp_data", rsp_data3, 8'h5A);
        check("l3_resp_rstb", {7'b0, read_strobe3}, 8'h00);
        in_port3 = 8'hFF;
        tick;
        check("l3_hold_data", rsp_data3, 8'h5A);
        check("l3_hold_vld", {7'b0, rsp_valid3}, 8'h01);
        rsp_ready3 = 1'b1;
        tick;
        check("l3_idle_rdy", {7'b0, cmd_ready3}, 8'h01);
        $display("[TB] READ_LAT=3 read data=%h done", rsp_data3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
